// File: rtl/instr_fetch_decode.sv
// Instruction fetch and IF/ID decode front-end for the 27-bit core.
// Drives the program ROM address from the PC, latches the returned word
// with its decoded flags, and stops fetching once a HALT word is latched.
module instr_fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [15:0]      prom_addr,
    input  logic [26:0]      prom_data,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [15:0]      br_target,
    output logic             ifid_valid,
    output logic [15:0]      ifid_pc,
    output logic             ifid_imm_flag,
    output logic [3:0]       ifid_opcode,
    output logic [2:0]       ifid_rd,
    output logic [2:0]       ifid_rs1,
    output logic [2:0]       ifid_rs2,
    output logic [15:0]      ifid_imm,
    output logic             ifid_is_nop,
    output logic             ifid_is_halt,
    output logic             ifid_is_branch,
    output logic             ifid_illegal,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

    state_e             state_q;
    logic [15:0]        pc_q;
    logic               valid_q;
    logic [15:0]        ifid_pc_q;
    logic [26:0]        word_q;
    logic               is_nop_q;
    logic               is_halt_q;
    logic               is_branch_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   count_q;

    logic [3:0]         dec_opcode;
    logic               dec_is_nop;
    logic               dec_is_halt;
    logic               dec_is_branch;
    logic               dec_illegal;

    // Decode flags of the word currently on the ROM bus
    always_comb begin
        dec_opcode    = prom_data[25:22];
        dec_is_nop    = (prom_data[26:22] == 5'b00000);
        dec_is_halt   = (prom_data[26:22] == 5'b10000);
        dec_is_branch = (dec_opcode == 4'b1101);
        case (dec_opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0101,
            4'b0110, 4'b1011, 4'b1101: dec_illegal = 1'b0;
            default:                   dec_illegal = 1'b1;
        endcase
    end

    // Fetch FSM with PC, IF/ID register and saturating fetch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            ifid_pc_q   <= '0;
            word_q      <= '0;
            is_nop_q    <= 1'b0;
            is_halt_q   <= 1'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                // First cycle after reset release: ROM output not yet trusted
                StBoot: state_q <= StRun;
                StRun: begin
                    if (br_taken) begin
                        pc_q    <= br_target;
                        valid_q <= 1'b0;
                    end else if (!stall) begin
                        valid_q     <= 1'b1;
                        ifid_pc_q   <= pc_q;
                        word_q      <= prom_data;
                        is_nop_q    <= dec_is_nop;
                        is_halt_q   <= dec_is_halt;
                        is_branch_q <= dec_is_branch;
                        illegal_q   <= dec_illegal;
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        // PC parks on the HALT address
                        if (dec_is_halt) begin
                            state_q <= StHalted;
                        end else begin
                            pc_q <= pc_q + 16'd1;
                        end
                    end
                end
                StHalted: begin
                    // A redirect here means the HALT was on the wrong path
                    if (br_taken) begin
                        pc_q    <= br_target;
                        valid_q <= 1'b0;
                        state_q <= StRun;
                    end else if (!stall) begin
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign prom_addr      = pc_q;
    assign halted         = (state_q == StHalted);
    assign ifid_valid     = valid_q;
    assign ifid_pc        = ifid_pc_q;
    assign ifid_imm_flag  = word_q[26];
    assign ifid_opcode    = word_q[25:22];
    assign ifid_rd        = word_q[21:19];
    assign ifid_rs1       = word_q[18:16];
    assign ifid_rs2       = word_q[2:0];
    assign ifid_imm       = word_q[15:0];
    assign ifid_is_nop    = is_nop_q;
    assign ifid_is_halt   = is_halt_q;
    assign ifid_is_branch = is_branch_q;
    assign ifid_illegal   = illegal_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a fetch scoreboard.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] prom_addr;
    logic [26:0] prom_data;
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic        ifid_imm_flag;
    logic [3:0]  ifid_opcode;
    logic [2:0]  ifid_rd;
    logic [2:0]  ifid_rs1;
    logic [2:0]  ifid_rs2;
    logic [15:0] ifid_imm;
    logic        ifid_is_nop;
    logic        ifid_is_halt;
    logic        ifid_is_branch;
    logic        ifid_illegal;
    logic        halted;
    logic [15:0] fetch_count;

    // Second instance: PC wrap from RESET_PC=FFFE
    logic [15:0] w_addr;
    logic        w_valid, w_imm_flag, w_is_nop, w_is_halt, w_is_branch, w_illegal, w_halted;
    logic [15:0] w_pc, w_imm, w_count;
    logic [3:0]  w_opcode;
    logic [2:0]  w_rd, w_rs1, w_rs2;

    // Third instance: 2-bit saturating counter
    logic [15:0] s_addr;
    logic        s_valid, s_imm_flag, s_is_nop, s_is_halt, s_is_branch, s_illegal, s_halted;
    logic [15:0] s_pc, s_imm;
    logic [1:0]  s_count;
    logic [3:0]  s_opcode;
    logic [2:0]  s_rd, s_rs1, s_rs2;

    logic [26:0] rom [0:255];
    assign prom_data = rom[prom_addr[7:0]];

    always #5 clk = ~clk;

    instr_fetch_decode u_dut (
        .clk(clk), .rst_n(rst_n), .prom_addr(prom_addr), .prom_data(prom_data),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_imm_flag(ifid_imm_flag),
        .ifid_opcode(ifid_opcode), .ifid_rd(ifid_rd), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2), .ifid_imm(ifid_imm), .ifid_is_nop(ifid_is_nop),
        .ifid_is_halt(ifid_is_halt), .ifid_is_branch(ifid_is_branch),
        .ifid_illegal(ifid_illegal), .halted(halted), .fetch_count(fetch_count)
    );

    instr_fetch_decode #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .prom_addr(w_addr), .prom_data(27'd0),
        .stall(1'b0), .br_taken(1'b0), .br_target(16'd0),
        .ifid_valid(w_valid), .ifid_pc(w_pc), .ifid_imm_flag(w_imm_flag),
        .ifid_opcode(w_opcode), .ifid_rd(w_rd), .ifid_rs1(w_rs1),
        .ifid_rs2(w_rs2), .ifid_imm(w_imm), .ifid_is_nop(w_is_nop),
        .ifid_is_halt(w_is_halt), .ifid_is_branch(w_is_branch),
        .ifid_illegal(w_illegal), .halted(w_halted), .fetch_count(w_count)
    );

    instr_fetch_decode #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .prom_addr(s_addr), .prom_data(27'd0),
        .stall(1'b0), .br_taken(1'b0), .br_target(16'd0),
        .ifid_valid(s_valid), .ifid_pc(s_pc), .ifid_imm_flag(s_imm_flag),
        .ifid_opcode(s_opcode), .ifid_rd(s_rd), .ifid_rs1(s_rs1),
        .ifid_rs2(s_rs2), .ifid_imm(s_imm), .ifid_is_nop(s_is_nop),
        .ifid_is_halt(s_is_halt), .ifid_is_branch(s_is_branch),
        .ifid_illegal(s_illegal), .halted(s_halted), .fetch_count(s_count)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [26:0] word;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare IF/ID against the oldest outstanding fetch
    task automatic check_ifid();
        exp_t       e;
        logic [3:0] op;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e  = sb.pop_front();
        op = e.word[25:22];
        chk("valid",     32'(ifid_valid),     32'd1);
        chk("pc",        32'(ifid_pc),        32'(e.pc));
        chk("imm_flag",  32'(ifid_imm_flag),  32'(e.word[26]));
        chk("opcode",    32'(ifid_opcode),    32'(op));
        chk("rd",        32'(ifid_rd),        32'(e.word[21:19]));
        chk("rs1",       32'(ifid_rs1),       32'(e.word[18:16]));
        chk("rs2",       32'(ifid_rs2),       32'(e.word[2:0]));
        chk("imm",       32'(ifid_imm),       32'(e.word[15:0]));
        chk("is_nop",    32'(ifid_is_nop),    32'(e.word[26:22] == 5'b00000));
        chk("is_halt",   32'(ifid_is_halt),   32'(e.word[26:22] == 5'b10000));
        chk("is_branch", 32'(ifid_is_branch), 32'(op == 4'hD));
        chk("illegal",   32'(ifid_illegal),
            32'(!(op inside {4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'hB, 4'hD})));
        chk("fetch_count", 32'(fetch_count), 32'(exp_cnt));
    endtask

    // One unstalled fetch from address a
    task automatic fetch(input logic [15:0] a);
        chk("prom_addr_pre", 32'(prom_addr), 32'(a));
        sb.push_back('{pc: a, word: rom[a[7:0]]});
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        tick();
        check_ifid();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 27'd0;
        rom[0]  = 27'b1_0001_000_101_1000000000001011;
        rom[8]  = 27'b0_1011_010_000_0000000000000001;
        rom[50] = 27'b0_0011_001_010_0000000000000111;
        rom[51] = 27'b0_1101_011_100_0000000000000101;
        rom[69] = 27'b1_0000_000_000_0000000000000000;

        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'd0;
        #12;
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_pc", 32'(ifid_pc), 32'd0);
        chk("rst_opcode", 32'(ifid_opcode), 32'd0);
        chk("rst_is_nop", 32'(ifid_is_nop), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_addr", 32'(prom_addr), 32'd0);
        chk("wrap_rst_addr", 32'(w_addr), 32'hFFFE);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("boot_valid", 32'(ifid_valid), 32'd0);
        chk("boot_addr", 32'(prom_addr), 32'd0);
        chk("wrap_boot_addr", 32'(w_addr), 32'hFFFE);

        fetch(16'd0);
        chk("w0_opcode", 32'(ifid_opcode), 32'd1);
        chk("w0_rs1", 32'(ifid_rs1), 32'd5);
        chk("w0_imm", 32'(ifid_imm), 32'h800B);
        chk("w0_next_addr", 32'(prom_addr), 32'd1);
        chk("wrap_addr1", 32'(w_addr), 32'hFFFF);
        fetch(16'd1);
        chk("wrap_addr2", 32'(w_addr), 32'h0000);
        chk("sat_count2", 32'(s_count), 32'd2);
        fetch(16'd2);
        fetch(16'd3);
        chk("nop3", 32'(ifid_is_nop), 32'd1);
        chk("count4", 32'(fetch_count), 32'd4);

        for (int a = 4; a <= 8; a++) fetch(16'(a));
        chk("w8_opcode", 32'(ifid_opcode), 32'hB);
        chk("w8_rs2", 32'(ifid_rs2), 32'd1);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(ifid_pc), 32'd8);
            chk("stall_valid", 32'(ifid_valid), 32'd1);
            chk("stall_addr", 32'(prom_addr), 32'd9);
            chk("stall_count", 32'(fetch_count), 32'(exp_cnt));
        end
        chk("sat_count3", 32'(s_count), 32'd3);
        stall = 1'b0;
        for (int a = 9; a <= 65; a++) fetch(16'(a));

        // Redirect overrides stall
        stall = 1'b1; br_taken = 1'b1; br_target = 16'd33;
        tick();
        chk("br_valid", 32'(ifid_valid), 32'd0);
        chk("br_addr", 32'(prom_addr), 32'd33);
        chk("br_count", 32'(fetch_count), 32'(exp_cnt));
        stall = 1'b0; br_taken = 1'b0;
        for (int a = 33; a <= 69; a++) fetch(16'(a));

        // HALT latched at 69
        chk("halted", 32'(halted), 32'd1);
        chk("halt_addr", 32'(prom_addr), 32'd69);
        stall = 1'b1;
        tick();
        chk("halt_stall_valid", 32'(ifid_valid), 32'd1);
        chk("halt_stall_is_halt", 32'(ifid_is_halt), 32'd1);
        stall = 1'b0;
        tick();
        chk("halt_drop_valid", 32'(ifid_valid), 32'd0);
        chk("halt_hold_addr", 32'(prom_addr), 32'd69);
        tick();
        chk("halt_still_invalid", 32'(ifid_valid), 32'd0);
        chk("halt_count_frozen", 32'(fetch_count), 32'(exp_cnt));
        chk("halt_still_halted", 32'(halted), 32'd1);

        br_taken = 1'b1; br_target = 16'd49;
        tick();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_valid", 32'(ifid_valid), 32'd0);
        chk("resume_addr", 32'(prom_addr), 32'd49);
        br_taken = 1'b0;
        fetch(16'd49);
        fetch(16'd50);
        fetch(16'd51);
        chk("bneq_no_redirect", 32'(prom_addr), 32'd52);

        // Redirect wins over a HALT on the ROM bus
        br_taken = 1'b1; br_target = 16'd69;
        tick();
        chk("to69_addr", 32'(prom_addr), 32'd69);
        br_target = 16'd10;
        tick();
        chk("brhalt_halted", 32'(halted), 32'd0);
        chk("brhalt_valid", 32'(ifid_valid), 32'd0);
        chk("brhalt_addr", 32'(prom_addr), 32'd10);
        chk("brhalt_count", 32'(fetch_count), 32'(exp_cnt));
        br_taken = 1'b0;
        fetch(16'd10);
        fetch(16'd11);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ifid_valid), 32'd0);
        chk("arst_pc", 32'(ifid_pc), 32'd0);
        chk("arst_addr", 32'(prom_addr), 32'd0);
        chk("arst_count", 32'(fetch_count), 32'd0);
        chk("arst_is_nop", 32'(ifid_is_nop), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_wrap_addr", 32'(w_addr), 32'hFFFE);
        sb.delete();
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reboot_valid", 32'(ifid_valid), 32'd0);
        fetch(16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
Front-end of the 27-bit core. It drives the program ROM address, captures the returned instruction word into an IF/ID pipeline register, and decodes its fields for the execute stage. It honours stall and branch-redirect inputs from later stages. It stops fetching when it decodes HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
CNT_W, 16, width of the saturating fetch counter.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
prom_addr  output  16  ROM address; always equals the internal PC
prom_data  input  27  ROM word; combinational, valid in the same cycle as prom_addr
stall  input  1  hold PC and IF/ID contents
br_taken  input  1  redirect from execute stage; flushes IF/ID
br_target  input  16  redirect PC, sampled when br_taken=1
ifid_valid  output  1  IF/ID holds a live instruction
ifid_pc  output  16  address the IF/ID word was fetched from
ifid_imm_flag  output  1  word bit 26
ifid_opcode  output  4  word bits 25:22
ifid_rd  output  3  word bits 21:19
ifid_rs1  output  3  word bits 18:16
ifid_rs2  output  3  word bits 2:0 (register-form second source)
ifid_imm  output  16  word bits 15:0
ifid_is_nop  output  1  imm_flag=0 and opcode=0000
ifid_is_halt  output  1  imm_flag=1 and opcode=0000
ifid_is_branch  output  1  opcode=1101 (BNEQ)
ifid_illegal  output  1  opcode not in {0000,0001,0010,0101,0110,1011,1101}
halted  output  1  fetch stopped on HALT
fetch_count  output  CNT_W  count of words latched into IF/ID; saturating

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; state=BOOT.
  - All ifid_* outputs are 0 and ifid_valid=0.
  - halted=0; fetch_count=0.
- FSM has three states: BOOT, RUN, HALTED.
- BOOT: lasts one cycle after reset is released. prom_addr=RESET_PC, nothing is latched, next state is RUN. This absorbs the reset-release edge.
- RUN, evaluated in priority order each cycle:
  - br_taken=1: PC<=br_target, ifid_valid<=0. This overrides stall.
  - else stall=1: PC and all IF/ID outputs hold; fetch_count holds.
  - else:
    - IF/ID<=decode(prom_data), ifid_pc<=PC, ifid_valid<=1.
    - PC<=PC+1, wrapping 16'hFFFF->16'h0000.
    - fetch_count+=1, saturating at all-ones.
    - If the latched word is HALT: state<=HALTED, PC holds (is not incremented).
- Latency: a word at address A appears on the ifid_* outputs one clock after prom_addr=A, unless stalled.
- HALTED:
  - halted=1 combinationally from state. prom_addr holds at the HALT address.
  - The HALT word stays in IF/ID while stall=1. On the first cycle with stall=0, ifid_valid<=0 and stays 0.
  - br_taken=1 means an older branch resolved, so the HALT was wrong-path: PC<=br_target, ifid_valid<=0, state<=RUN, halted deasserts next cycle.
- Decode is a pure bit-slice plus the flag equations above, registered together with ifid_valid. Fields are latched even when ifid_illegal=1; the core decides the trap.
- A BNEQ word itself causes no redirect here; only br_taken does.
- Simultaneous br_taken with a HALT on prom_data: the redirect wins, the HALT is not latched, state stays RUN.
- rst_n asserted mid-operation: immediate return to reset values regardless of state or stall.

Test Plan:
- Reset, then run without stall, ROM[0]=27'b1_0001_000_101_1000000000001011:
  - 2nd edge after release: ifid_valid=1, pc=0, imm_flag=1, opcode=1, rd=0, rs1=5, imm=16'h800B.
  - Following edge: prom_addr=1.
- Straight-line NOP stream at 1..3: is_nop=1 each cycle, fetch_count reaches 4 at pc=3, no illegal flag.
- Stall held 3 cycles while IF/ID holds pc=8 (word 0_1011_010_000_...0001):
  - IF/ID and prom_addr=9 stay constant.
  - After release, next latched pc=9.
  - opcode=1011, rs2=1.
- br_taken=1 with br_target=33 while stall=1 and pc=66:
  - Next cycle: ifid_valid=0, prom_addr=33, with the stall ignored.
  - Cycle after: pc=33 valid.
- HALT at 69 (27'b1_0000_...0):
  - Latched with is_halt=1, then halted=1.
  - prom_addr stays 69; ifid_valid drops one cycle later.
  - fetch_count frozen.
  - Then br_taken with target 49 resumes RUN with pc=49.
- Wrap and saturation:
  - RESET_PC=16'hFFFE: addresses go FFFE, FFFF, 0000.
  - CNT_W=2: fetch_count saturates at 3.
  - rst_n pulse mid-run clears all outputs asynchronously, before the next clock edge.
